ftq_buffer: RTL and testbench
=============================

Name: ftq_buffer

Overview:
Fetch Target Queue between the BPU and the ICache fetch stage. It buffers predicted fetch blocks and issues them in order to the ICache. Each entry is retained until the ROB commits it. The block is the requester side of the pipeline stop/flush protocol: it raises FTQReq when it is nearly full, and it obeys the FTQStop and FTQFlash signals returned by the pipeline controller.

Parameters:
DEPTH, 8, number of entries; must be a power of 2 and at least 4.
PC_W, 32, width of the PC and target fields.
META_W, 8, width of the opaque predictor metadata carried with each entry.
AFULL_TH, 2, FTQReq asserts when free slots <= AFULL_TH; must be less than DEPTH.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rest  in  1  asynchronous, active-low reset.
FTQStop  in  1  from controller; blocks enqueue only.
FTQFlash  in  1  from controller; clears the whole queue.
EnqValid  in  1  BPU offers a fetch block.
EnqPc  in  PC_W  start PC of the block.
EnqTarget  in  PC_W  predicted next PC.
EnqTaken  in  1  prediction taken.
EnqMeta  in  META_W  predictor metadata.
DeqReady  in  1  ICache can accept a fetch block.
DeqValid  out  1  a fetch block is available for issue.
DeqPc  out  PC_W  PC field of the entry at the fetch pointer.
DeqTarget  out  PC_W  target field of the entry at the fetch pointer.
DeqTaken  out  1  taken field of the entry at the fetch pointer.
DeqMeta  out  META_W  metadata field of the entry at the fetch pointer.
DeqIdx  out  log2(DEPTH)  queue index of the issued entry; used as the FTQ tag downstream.
CommitValid  in  1  ROB retires the oldest fetched entry.
FTQReq  out  1  registered almost-full request to the controller.
Count  out  log2(DEPTH)+1  number of occupied entries (enqueued and not yet committed).

Behaviour:
- Storage: DEPTH entries, each holding {Pc, Target, Taken, Meta}.
- Pointers: three pointers, enq, fetch and commit. Each is log2(DEPTH) bits plus a wrap bit.
  - Invariant: commit <= fetch <= enq, in wrap order.
  - Pointers wrap from DEPTH-1 to 0 and toggle their wrap bit.
- Reset (Rest=0, asynchronous): all pointers 0, Count=0, FTQReq=0, DeqValid=0. Entry storage is not reset. The block resumes on the first rising edge after Rest deasserts.
- Enqueue: accepted when EnqValid & ~FTQStop & ~full & ~FTQFlash.
  - full means Count==DEPTH.
  - An accepted block is written at enq, and enq increments.
  - A block that is not accepted is not written; the BPU holds it, because the controller stalls the BPU with the same Stop.
- Issue:
  - DeqValid = (fetch != enq), driven from registers.
  - The Deq* data outputs reflect the entry at fetch.
  - An entry enqueued in cycle N is visible on DeqValid in cycle N+1. There is no bypass path.
  - The issue handshake (DeqValid & DeqReady & ~FTQFlash) increments fetch.
  - DeqValid must not depend combinationally on DeqReady.
- FTQStop never blocks issue or commit. The queue must drain while FTQReq is raised, otherwise the stall loop through the controller deadlocks.
- Commit: CommitValid & (commit != fetch) & ~FTQFlash increments commit. CommitValid with no fetched, uncommitted entry is ignored and changes no state.
- Count: next Count = Count + enq_fire - commit_fire. Enqueue and commit in the same cycle leave Count unchanged.
- FTQReq: registered, FTQReq <= (DEPTH - Count_next) <= AFULL_TH. It therefore tracks the new occupancy one cycle after the update.
- FTQFlash: highest priority.
  - Enqueue, issue and commit in the same cycle are all ignored.
  - In the next cycle: enq=fetch=commit=0, Count=0, DeqValid=0, FTQReq=0.
  - FTQFlash held for several cycles keeps the queue empty.
- Full boundary: when Count==DEPTH, the queue accepts no enqueue even with FTQStop low. A commit in the same cycle frees a slot only for the following cycle.
- Empty boundary: when fetch==enq, DeqValid=0 and DeqReady is ignored.

Test Plan:
1. Reset then idle: Rest pulsed low mid-cycle -> all outputs 0 immediately (asynchronous); EnqValid=1 with EnqPc=0x1C000000, DeqReady=0 -> DeqValid=1 one cycle later with DeqPc=0x1C000000 and DeqIdx=0; Count=1.
2. Almost full (DEPTH=8, AFULL_TH=2): enqueue 6 blocks with no issue or commit -> FTQReq=1 the cycle after Count reaches 6. Assert FTQStop with EnqValid held -> no writes, Count stays 6. Commit nothing, drive DeqReady=1 -> issues continue while FTQStop=1.
3. Full and simultaneous enqueue/commit: fill to Count=8 with FTQStop=0 -> the 9th EnqValid is rejected. Issue one entry, then CommitValid with EnqValid in the same cycle -> enqueue rejected (still full) and Count=7. Next cycle: enqueue accepted, Count=8.
4. Flush mid-operation: Count=5, fetch=3; assert FTQFlash with EnqValid, DeqReady and CommitValid all high -> next cycle Count=0, DeqValid=0, FTQReq=0, DeqIdx=0. The new enqueue lands at index 0.
5. Wrap-around: stream 20 blocks with DeqReady=1 and a commit each cycle after issue -> DeqIdx sequence 0..7,0..7,0..3. PCs come out in order with none lost. Count never exceeds 3.
6. Illegal commit: Count=2, none issued, CommitValid=1 -> commit pointer and Count unchanged. Then issue one entry and commit -> Count=1.

Source files
------------

// File: rtl/ftq_buffer.sv
// Fetch Target Queue: buffers predicted fetch blocks from the BPU, issues them in
// order to the ICache and retains each one until the ROB commits it.
module ftq_buffer #(
    parameter int DEPTH    = 8,
    parameter int PC_W     = 32,
    parameter int META_W   = 8,
    parameter int AFULL_TH = 2,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              FTQStop,
    input  logic              FTQFlash,
    input  logic              EnqValid,
    input  logic [PC_W-1:0]   EnqPc,
    input  logic [PC_W-1:0]   EnqTarget,
    input  logic              EnqTaken,
    input  logic [META_W-1:0] EnqMeta,
    input  logic              DeqReady,
    output logic              DeqValid,
    output logic [PC_W-1:0]   DeqPc,
    output logic [PC_W-1:0]   DeqTarget,
    output logic              DeqTaken,
    output logic [META_W-1:0] DeqMeta,
    output logic [IDX_W-1:0]  DeqIdx,
    input  logic              CommitValid,
    output logic              FTQReq,
    output logic [CNT_W-1:0]  Count
);

    logic [PC_W-1:0]   pcMem     [DEPTH];
    logic [PC_W-1:0]   targetMem [DEPTH];
    logic              takenMem  [DEPTH];
    logic [META_W-1:0] metaMem   [DEPTH];

    // Pointers carry an extra wrap bit so equal indices can be told apart as empty or full.
    logic [IDX_W:0]   enqPtr;
    logic [IDX_W:0]   fetchPtr;
    logic [IDX_W:0]   commitPtr;
    logic [CNT_W-1:0] count;
    logic             ftqReq;

    logic             full;
    logic             enqFire;
    logic             deqFire;
    logic             commitFire;
    logic [CNT_W-1:0] countNext;
    logic [CNT_W-1:0] freeNext;
    logic             reqNext;

    assign full       = (count == CNT_W'(DEPTH));
    assign DeqValid   = (fetchPtr != enqPtr);
    assign enqFire    = EnqValid & ~FTQStop & ~full & ~FTQFlash;
    assign deqFire    = DeqValid & DeqReady & ~FTQFlash;
    assign commitFire = CommitValid & (commitPtr != fetchPtr) & ~FTQFlash;

    assign countNext  = count + CNT_W'(enqFire) - CNT_W'(commitFire);
    assign freeNext   = CNT_W'(DEPTH) - countNext;
    assign reqNext    = (freeNext <= CNT_W'(AFULL_TH));

    // Flash has priority over every other update and returns the queue to its reset state.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            enqPtr    <= '0;
            fetchPtr  <= '0;
            commitPtr <= '0;
            count     <= '0;
            ftqReq    <= 1'b0;
        end else if (FTQFlash) begin
            enqPtr    <= '0;
            fetchPtr  <= '0;
            commitPtr <= '0;
            count     <= '0;
            ftqReq    <= 1'b0;
        end else begin
            if (enqFire)    enqPtr    <= enqPtr + 1'b1;
            if (deqFire)    fetchPtr  <= fetchPtr + 1'b1;
            if (commitFire) commitPtr <= commitPtr + 1'b1;
            count  <= countNext;
            ftqReq <= reqNext;
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (enqFire) begin
            pcMem[enqPtr[IDX_W-1:0]]     <= EnqPc;
            targetMem[enqPtr[IDX_W-1:0]] <= EnqTarget;
            takenMem[enqPtr[IDX_W-1:0]]  <= EnqTaken;
            metaMem[enqPtr[IDX_W-1:0]]   <= EnqMeta;
        end
    end

    assign DeqIdx    = fetchPtr[IDX_W-1:0];
    assign DeqPc     = pcMem[fetchPtr[IDX_W-1:0]];
    assign DeqTarget = targetMem[fetchPtr[IDX_W-1:0]];
    assign DeqTaken  = takenMem[fetchPtr[IDX_W-1:0]];
    assign DeqMeta   = metaMem[fetchPtr[IDX_W-1:0]];
    assign FTQReq    = ftqReq;
    assign Count     = count;

endmodule

// File: tb/tb_ftq_buffer.sv
// Self-checking bench for ftq_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the FTQ.
module tb_ftq_buffer;

    localparam int DEPTH    = 8;
    localparam int PC_W     = 32;
    localparam int META_W   = 8;
    localparam int AFULL_TH = 2;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   target;
        logic              taken;
        logic [META_W-1:0] meta;
    } entry_t;

    logic              Clk;
    logic              Rest;
    logic              FTQStop;
    logic              FTQFlash;
    logic              EnqValid;
    logic [PC_W-1:0]   EnqPc;
    logic [PC_W-1:0]   EnqTarget;
    logic              EnqTaken;
    logic [META_W-1:0] EnqMeta;
    logic              DeqReady;
    logic              DeqValid;
    logic [PC_W-1:0]   DeqPc;
    logic [PC_W-1:0]   DeqTarget;
    logic              DeqTaken;
    logic [META_W-1:0] DeqMeta;
    logic [2:0]        DeqIdx;
    logic              CommitValid;
    logic              FTQReq;
    logic [3:0]        Count;

    int checks = 0;
    int errors = 0;

    // Model state: uncommitted entries in age order, how many of them are issued,
    // and the absolute sequence number of the oldest one.
    entry_t modelQ[$];
    int     modelFetched = 0;
    int     modelHeadSeq = 0;
    bit     modelReq     = 0;

    ftq_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .META_W(META_W), .AFULL_TH(AFULL_TH)) dut (
        .Clk(Clk), .Rest(Rest), .FTQStop(FTQStop), .FTQFlash(FTQFlash),
        .EnqValid(EnqValid), .EnqPc(EnqPc), .EnqTarget(EnqTarget), .EnqTaken(EnqTaken),
        .EnqMeta(EnqMeta), .DeqReady(DeqReady), .DeqValid(DeqValid), .DeqPc(DeqPc),
        .DeqTarget(DeqTarget), .DeqTaken(DeqTaken), .DeqMeta(DeqMeta), .DeqIdx(DeqIdx),
        .CommitValid(CommitValid), .FTQReq(FTQReq), .Count(Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advanced on each clock edge from the inputs as seen at that edge.
    always @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            modelQ.delete();
            modelFetched = 0;
            modelHeadSeq = 0;
            modelReq     = 0;
        end else begin
            bit enqOk, deqOk, comOk;
            entry_t e;
            enqOk = EnqValid && !FTQStop && !FTQFlash && (modelQ.size() < DEPTH);
            deqOk = DeqReady && !FTQFlash && (modelFetched < modelQ.size());
            comOk = CommitValid && !FTQFlash && (modelFetched > 0);
            if (FTQFlash) begin
                modelQ.delete();
                modelFetched = 0;
                modelHeadSeq = 0;
                modelReq     = 0;
            end else begin
                if (comOk) begin
                    void'(modelQ.pop_front());
                    modelHeadSeq++;
                    modelFetched--;
                end
                if (deqOk) modelFetched++;
                if (enqOk) begin
                    e.pc = EnqPc; e.target = EnqTarget; e.taken = EnqTaken; e.meta = EnqMeta;
                    modelQ.push_back(e);
                end
                modelReq = (DEPTH - modelQ.size()) <= AFULL_TH;
            end
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge Clk) begin
        if (Rest) begin
            bit expValid;
            expValid = modelFetched < modelQ.size();
            checkOutput("DeqValid", DeqValid, expValid);
            checkOutput("Count", Count, modelQ.size());
            checkOutput("FTQReq", FTQReq, modelReq);
            checkOutput("DeqIdx", DeqIdx, (modelHeadSeq + modelFetched) % DEPTH);
            if (expValid) begin
                checkOutput("DeqPc", DeqPc, modelQ[modelFetched].pc);
                checkOutput("DeqTarget", DeqTarget, modelQ[modelFetched].target);
                checkOutput("DeqTaken", DeqTaken, modelQ[modelFetched].taken);
                checkOutput("DeqMeta", DeqMeta, modelQ[modelFetched].meta);
            end
        end
    end

    // Drives one cycle of inputs just after a rising edge and returns just after the next one.
    task automatic applyStimulus(input bit enqV, input bit stop, input bit flash,
                                 input bit deqR, input bit comV, input logic [PC_W-1:0] pc);
        EnqValid    = enqV;
        FTQStop     = stop;
        FTQFlash    = flash;
        DeqReady    = deqR;
        CommitValid = comV;
        EnqPc       = pc;
        EnqTarget   = $urandom;
        EnqTaken    = 1'($urandom_range(0, 1));
        EnqMeta     = 8'($urandom);
        @(posedge Clk);
        #1;
    endtask

    task automatic idleInputs();
        EnqValid = 0; FTQStop = 0; FTQFlash = 0; DeqReady = 0; CommitValid = 0;
    endtask

    // Pulses the asynchronous reset in the middle of a cycle and checks it acts at once.
    task automatic doReset();
        idleInputs();
        #3;
        Rest = 1'b0;
        #1;
        checkOutput("rstDeqValid", DeqValid, 0);
        checkOutput("rstCount", Count, 0);
        checkOutput("rstFTQReq", FTQReq, 0);
        checkOutput("rstDeqIdx", DeqIdx, 0);
        @(negedge Clk);
        Rest = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int issued;
        logic [PC_W-1:0] streamPc;
        Rest = 1'b0;
        idleInputs();
        EnqPc = '0; EnqTarget = '0; EnqTaken = 0; EnqMeta = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rest = 1'b1;
        @(posedge Clk);
        #1;

        // Reset then a single enqueue with no issue.
        applyStimulus(1, 0, 0, 0, 0, 32'h1234_0000);
        applyStimulus(1, 0, 0, 0, 0, 32'h1234_0004);
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 32'h1C00_0000);
        checkOutput("t1DeqValid", DeqValid, 1);
        checkOutput("t1DeqPc", DeqPc, 32'h1C00_0000);
        checkOutput("t1DeqIdx", DeqIdx, 0);
        checkOutput("t1Count", Count, 1);

        // Almost-full request, Stop blocking enqueue but not issue.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 32'h2000_0000 + 32'(i * 4));
        checkOutput("t2ReqAt5", FTQReq, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h2000_0014);
        checkOutput("t2CountAt6", Count, 6);
        checkOutput("t2ReqAt6", FTQReq, 1);
        applyStimulus(1, 1, 0, 0, 0, 32'h2000_0018);
        applyStimulus(1, 1, 0, 0, 0, 32'h2000_0018);
        checkOutput("t2StopCount", Count, 6);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0, 32'h2000_0018);
        checkOutput("t2StopIssueIdx", DeqIdx, 3);
        checkOutput("t2StopIssuePc", DeqPc, 32'h2000_000C);
        checkOutput("t2StopIssueCount", Count, 6);

        // Full queue, rejected enqueue, simultaneous commit and enqueue.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 32'h3000_0000 + 32'(i * 4));
        checkOutput("t3CountFull", Count, 8);
        applyStimulus(1, 0, 0, 0, 0, 32'h3000_0020);
        checkOutput("t3NinthRejected", Count, 8);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 32'h3000_0020);
        checkOutput("t3CommitWhileFull", Count, 7);
        applyStimulus(1, 0, 0, 0, 0, 32'h3000_0020);
        checkOutput("t3RefillCount", Count, 8);

        // Flush with every other request active.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 32'h4000_0000 + 32'(i * 4));
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 32'h0);
        checkOutput("t4PreCount", Count, 5);
        checkOutput("t4PreIdx", DeqIdx, 3);
        applyStimulus(1, 0, 1, 1, 1, 32'h4000_00FF);
        checkOutput("t4Count", Count, 0);
        checkOutput("t4DeqValid", DeqValid, 0);
        checkOutput("t4FTQReq", FTQReq, 0);
        checkOutput("t4DeqIdx", DeqIdx, 0);
        applyStimulus(1, 0, 1, 0, 0, 32'h4000_00F0);
        applyStimulus(1, 0, 1, 0, 0, 32'h4000_00F0);
        checkOutput("t4HeldFlash", Count, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h4000_0100);
        checkOutput("t4NewIdx", DeqIdx, 0);
        checkOutput("t4NewPc", DeqPc, 32'h4000_0100);

        // Wrap-around streaming with issue and commit every cycle.
        doReset();
        issued = 0;
        for (int c = 0; c < 24; c++) begin
            streamPc = 32'h5000_0000 + 32'(c * 4);
            EnqValid = (c < 20); FTQStop = 0; FTQFlash = 0; DeqReady = 1; CommitValid = 1;
            EnqPc = streamPc; EnqTarget = $urandom; EnqTaken = 0; EnqMeta = 8'(c);
            if (DeqValid) begin
                checkOutput("t5Idx", DeqIdx, issued % DEPTH);
                checkOutput("t5Pc", DeqPc, 32'h5000_0000 + 32'(issued * 4));
                issued++;
            end
            checkOutput("t5CountMax", (Count <= 3), 1);
            @(posedge Clk);
            #1;
        end
        checkOutput("t5Issued", issued, 20);

        // Commit with nothing issued is ignored.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 32'h6000_0000);
        applyStimulus(1, 0, 0, 0, 0, 32'h6000_0004);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        checkOutput("t6IllegalCommit", Count, 2);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        checkOutput("t6IssueIdx", DeqIdx, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        checkOutput("t6LegalCommit", Count, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        checkOutput("t6NoSecondCommit", Count, 1);

        // Random traffic against the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55,
                          $urandom_range(0, 99) < 50, $urandom);
        end
        idleInputs();
        repeat (2) @(posedge Clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
